// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner and emulator.
// Holds key codes, row/column drive patterns, the emulator state encoding and
// the key-to-matrix-position lookup.
package keypad_pkg;

    // Key codes
    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // Row drive patterns (one-hot active-low) and the idle column level
    localparam logic [3:0] ROW0     = 4'b0111;
    localparam logic [3:0] ROW1     = 4'b1011;
    localparam logic [3:0] ROW2     = 4'b1101;
    localparam logic [3:0] ROW3     = 4'b1110;
    localparam logic [3:0] COL_NONE = 4'b1111;

    // Emulator state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESS   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Matrix position of a key: {row pattern that selects it, column it pulls low}
    function automatic logic [7:0] key_position(input logic [3:0] key);
        logic [7:0] pos;
        case (key)
            KEY_F:   pos = {ROW0, 4'b0111};
            KEY_E:   pos = {ROW0, 4'b1011};
            KEY_D:   pos = {ROW0, 4'b1101};
            KEY_C:   pos = {ROW0, 4'b1110};
            KEY_B:   pos = {ROW1, 4'b0111};
            KEY_3:   pos = {ROW1, 4'b1011};
            KEY_6:   pos = {ROW1, 4'b1101};
            KEY_9:   pos = {ROW1, 4'b1110};
            KEY_A:   pos = {ROW2, 4'b0111};
            KEY_2:   pos = {ROW2, 4'b1011};
            KEY_5:   pos = {ROW2, 4'b1101};
            KEY_8:   pos = {ROW2, 4'b1110};
            KEY_0:   pos = {ROW3, 4'b0111};
            KEY_1:   pos = {ROW3, 4'b1011};
            KEY_4:   pos = {ROW3, 4'b1101};
            default: pos = {ROW3, 4'b1110}; // KEY_7
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo: DEPTH x 4-bit synchronous FIFO holding pending key requests.
// Head entry is presented combinationally so the emulator can latch it on pop.
module keypad_key_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    assign dout  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: plays queued key codes into a 4x4 matrix keypad interface.
// Each key is held closed for HOLD_CYCLES, then released for GAP_CYCLES.
// Optional macro KEYPAD_BOUNCE_EN adds contact bounce at the start of each
// press and each release.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int HOLD_CYCLES   = 32,
    parameter int GAP_CYCLES    = 32,
    parameter int BOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:3] row,
    output logic [0:3] col,
    input  logic       in_valid,
    input  logic [3:0] in_key,
    output logic       in_ready,
    input  logic       flush,
    output logic       key_active,
    output logic [3:0] active_key,
    output logic       busy
);
    // Counter must span the hold, gap and bounce windows
    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_CYC = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic [3:0]       active_key_reg, active_key_next;
    logic             key_active_reg, key_active_next;
    logic             contact_now;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [3:0]       fifo_dout;
    logic [7:0]       key_pos;

    // Flush wins over a same-cycle push; pops only happen from IDLE
    assign fifo_push = in_valid && !fifo_full && !flush;
    assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty && !flush;

    keypad_key_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_key),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Contact level implied by the current state and counter
    always_comb begin
        contact_now = 1'b0;
        case (state_reg)
`ifdef KEYPAD_BOUNCE_EN
            ST_PRESS:   contact_now = (counter_reg < CNT_W'(BOUNCE_CYCLES)) ? !counter_reg[0] : 1'b1;
            ST_RELEASE: contact_now = (counter_reg < CNT_W'(BOUNCE_CYCLES)) ?  counter_reg[0] : 1'b0;
`else
            ST_PRESS:   contact_now = 1'b1;
            ST_RELEASE: contact_now = 1'b0;
`endif
            default:    contact_now = 1'b0;
        endcase
    end

    // Press/release sequencing
    always_comb begin
        state_next      = state_reg;
        counter_next    = counter_reg;
        active_key_next = active_key_reg;
        key_active_next = contact_now;
        if (flush) begin
            state_next      = ST_IDLE;
            counter_next    = '0;
            key_active_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_next      = ST_PRESS;
                        counter_next    = '0;
                        active_key_next = fifo_dout;
                    end
                end
                ST_PRESS: begin
                    if (counter_reg == HOLD_LAST) begin
                        state_next   = ST_RELEASE;
                        counter_next = '0;
                    end else begin
                        counter_next = counter_reg + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (counter_reg == GAP_LAST) begin
                        state_next   = ST_IDLE;
                        counter_next = '0;
                    end else begin
                        counter_next = counter_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next   = ST_IDLE;
                    counter_next = '0;
                end
            endcase
        end
    end

    // State registers; reset opens the contact without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            counter_reg    <= '0;
            active_key_reg <= '0;
            key_active_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            counter_reg    <= counter_next;
            active_key_reg <= active_key_next;
            key_active_reg <= key_active_next;
        end
    end

    assign key_pos = key_position(active_key_reg);

    // Column readout follows the scanner's row drive while the contact is closed
    always_comb begin
        col = COL_NONE;
        if (key_active_reg && (row == key_pos[7:4])) begin
            col = key_pos[3:0];
        end
    end

    assign in_ready   = !fifo_full;
    assign key_active = key_active_reg;
    assign active_key = active_key_reg;
    assign busy       = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: table-driven, directed and randomized checks of
// keypad_emulator against a schedule-based reference model.
module tb_keypad_emulator;
    localparam int DEPTH  = 4;
    localparam int HOLD   = 32;
    localparam int GAP    = 32;
    localparam int BOUNCE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:3] row;
    logic [0:3] col;
    logic       in_valid;
    logic [3:0] in_key;
    logic       in_ready;
    logic       flush;
    logic       key_active;
    logic [3:0] active_key;
    logic       busy;

    always #5 clk = ~clk;

    keypad_emulator #(
        .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .BOUNCE_CYCLES(BOUNCE)
    ) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .in_valid(in_valid), .in_key(in_key), .in_ready(in_ready),
        .flush(flush), .key_active(key_active), .active_key(active_key), .busy(busy)
    );

    // Keypad matrix from the datasheet table, indexed by key code
    logic [3:0] krow [16] = '{4'b1110, 4'b1110, 4'b1101, 4'b1011, 4'b1110, 4'b1101, 4'b1011, 4'b1110,
                              4'b1101, 4'b1011, 4'b1101, 4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
    logic [3:0] kcol [16] = '{4'b0111, 4'b1011, 4'b1011, 4'b1011, 4'b1101, 4'b1101, 4'b1101, 4'b1110,
                              4'b1110, 4'b1110, 4'b0111, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference schedule: per accepted key, accept edge n and first closed edge s
    int         q_n [$];
    int         q_s [$];
    logic [3:0] q_k [$];
    int         next_min  = 0;
    logic [3:0] base_akey = 4'h0;

    logic [3:0] obs [$];
    bit         prev_ka  = 1'b0;
    int         last_rec = -1000;

    function automatic bit m_ka(int t);
        foreach (q_s[i]) begin
            int d;
            d = t - q_s[i];
            if (d >= 0 && d < HOLD) begin
`ifdef KEYPAD_BOUNCE_EN
                if (d < BOUNCE) return (d % 2) == 0;
`endif
                return 1'b1;
            end
`ifdef KEYPAD_BOUNCE_EN
            if (d >= HOLD && d < HOLD + BOUNCE) return ((d - HOLD) % 2) == 1;
`endif
        end
        return 1'b0;
    endfunction

    function automatic bit m_busy(int t);
        foreach (q_s[i])
            if (q_n[i] <= t && t < q_s[i] - 1 + HOLD + GAP) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(int t);
        int occ = 0;
        foreach (q_s[i])
            if (q_n[i] <= t && t <= q_s[i] - 2) occ++;
        return occ < DEPTH;
    endfunction

    function automatic logic [3:0] m_akey(int t);
        logic [3:0] k = base_akey;
        foreach (q_s[i])
            if (q_s[i] - 1 <= t) k = q_k[i];
        return k;
    endfunction

    function automatic logic [3:0] m_col(int t);
        logic [3:0] k;
        k = m_akey(t);
        if (m_ka(t) && (row == krow[k])) return kcol[k];
        return 4'b1111;
    endfunction

    task automatic model_clear(logic [3:0] akey);
        q_n.delete(); q_s.delete(); q_k.delete();
        next_min  = 0;
        base_akey = akey;
    endtask

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("in_ready",   16'(in_ready),   16'(m_ready(cyc)));
        chk("key_active", 16'(key_active), 16'(m_ka(cyc)));
        chk("busy",       16'(busy),       16'(m_busy(cyc)));
        chk("col",        16'(col),        16'(m_col(cyc)));
        chk("active_key", 16'(active_key), 16'(m_akey(cyc)));
    endtask

    // One clock: predict the edge, advance, then check on the falling edge
    task automatic tick();
        bit         acc, fl;
        logic [3:0] k;
        int         s;
        acc = in_valid && !flush && m_ready(cyc);
        fl  = flush;
        k   = in_key;
        @(posedge clk);
        cyc++;
        if (fl) begin
            model_clear(m_akey(cyc - 1));
        end else if (acc) begin
            s = (cyc + 2 > next_min) ? cyc + 2 : next_min;
            q_n.push_back(cyc); q_s.push_back(s); q_k.push_back(k);
            next_min = s + HOLD + GAP + 1;
        end
        @(negedge clk);
        check_all();
        if (key_active && !prev_ka && (cyc - last_rec > HOLD)) begin
            obs.push_back(active_key);
            last_rec = cyc;
        end
        prev_ka = key_active;
    endtask

    task automatic push(logic [3:0] k);
        in_valid = 1'b1; in_key = k;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_ka(int limit);
        int g = 0;
        while (!key_active && g < limit) begin tick(); g++; end
        chk("wait_key_active", 16'(key_active), 16'd1);
    endtask

    task automatic wait_idle(int limit);
        int g = 0;
        while (busy && g < limit) begin tick(); g++; end
        chk("wait_idle", 16'(busy), 16'd0);
    endtask

    typedef struct { logic [3:0] row; logic [3:0] exp_col; } idle_vec_t;
    typedef struct { logic [3:0] key; logic [3:0] row; logic [3:0] exp_col; } press_vec_t;

    idle_vec_t  idle_tab  [7];
    press_vec_t press_tab [9];
    logic [3:0] full_keys [6];
    logic [3:0] exp_order [5];

    initial begin
        int         edge_n, hl, cnt;
        logic [3:0] bseq [6];

        idle_tab  = '{'{4'b0111, 4'b1111}, '{4'b1011, 4'b1111}, '{4'b1101, 4'b1111}, '{4'b1110, 4'b1111},
                      '{4'b0000, 4'b1111}, '{4'b1111, 4'b1111}, '{4'b0011, 4'b1111}};
        press_tab = '{'{4'h8, 4'b1101, 4'b1110}, '{4'h8, 4'b0111, 4'b1111}, '{4'h3, 4'b1011, 4'b1011},
                      '{4'hF, 4'b0111, 4'b0111}, '{4'h0, 4'b1110, 4'b0111}, '{4'hA, 4'b1101, 4'b0111},
                      '{4'h7, 4'b1110, 4'b1110}, '{4'h5, 4'b1101, 4'b1101}, '{4'h8, 4'b1100, 4'b1111}};
        full_keys = '{4'h9, 4'h6, 4'h2, 4'h5, 4'hF, 4'h1};
        exp_order = '{4'h9, 4'h6, 4'h2, 4'h5, 4'hF};

        reset = 1'b1; in_valid = 1'b0; in_key = 4'h0; flush = 1'b0; row = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear(4'h0);
        check_all();

        // Idle: every row pattern reads no contact
        foreach (idle_tab[i]) begin
            row = idle_tab[i].row;
            #1;
            chk("idle_col", 16'(col), 16'(idle_tab[i].exp_col));
            chk("idle_ready", 16'(in_ready), 16'd1);
            chk("idle_busy", 16'(busy), 16'd0);
            tick();
        end

        // Single presses: latency, column readout, hold length
        foreach (press_tab[i]) begin
            row = press_tab[i].row;
            push(press_tab[i].key);
            edge_n = cyc;
            wait_ka(10);
            chk("press_latency", 16'(cyc - edge_n), 16'd2);
            hl = 1;
            for (int j = 0; j < BOUNCE + 1; j++) begin tick(); if (key_active) hl++; end
            chk("press_col", 16'(col), 16'(press_tab[i].exp_col));
            cnt = 0;
            while (key_active && cnt < 100) begin tick(); cnt++; if (key_active) hl++; end
`ifndef KEYPAD_BOUNCE_EN
            chk("hold_len", 16'(hl), 16'(HOLD));
`endif
            wait_idle(200);
        end

        // Back-to-back requests fill the FIFO; the overflow push is dropped
        obs.delete();
        foreach (full_keys[i]) begin
            in_valid = 1'b1; in_key = full_keys[i];
            tick();
            if (i == 4) chk("full_ready", 16'(in_ready), 16'd0);
        end
        in_valid = 1'b0;
        wait_idle(800);
        chk("press_count", 16'(obs.size()), 16'd5);
        foreach (exp_order[i])
            if (i < obs.size()) chk("press_order", 16'(obs[i]), 16'(exp_order[i]));

        // Flush on cycle 10 of a press; the push in that cycle is lost
        row = 4'b0111;
        push(4'hC);
        wait_ka(10);
        repeat (9) tick();
        flush = 1'b1; in_valid = 1'b1; in_key = 4'h5;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_col", 16'(col), 16'hF);
        chk("flush_key_active", 16'(key_active), 16'd0);
        chk("flush_busy", 16'(busy), 16'd0);
        cnt = 0;
        for (int j = 0; j < 80; j++) begin tick(); if (key_active) cnt++; end
        chk("flush_push_lost", 16'(cnt), 16'd0);

        // Asynchronous reset mid-press releases the contact without a clock edge
        row = 4'b1011;
        push(4'h3);
        wait_ka(10);
        repeat (BOUNCE + 3) tick();
        chk("pre_reset_col", 16'(col), 16'b1011);
        #2 reset = 1'b1;
        #1;
        chk("async_col", 16'(col), 16'hF);
        chk("async_key_active", 16'(key_active), 16'd0);
        chk("async_busy", 16'(busy), 16'd0);
        chk("async_ready", 16'(in_ready), 16'd1);
        chk("async_active_key", 16'(active_key), 16'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear(4'h0);
        check_all();

`ifdef KEYPAD_BOUNCE_EN
        // Bounce on press and release of key 0 with row 1110
        row = 4'b1110;
        push(4'h0);
        wait_ka(10);
        bseq = '{4'b0111, 4'b1111, 4'b0111, 4'b1111, 4'b0111, 4'b0111};
        for (int j = 0; j < 6; j++) begin chk("bounce_press", 16'(col), 16'(bseq[j])); tick(); end
        repeat (HOLD - 6) tick();
        bseq = '{4'b1111, 4'b0111, 4'b1111, 4'b0111, 4'b1111, 4'b1111};
        for (int j = 0; j < 6; j++) begin chk("bounce_release", 16'(col), 16'(bseq[j])); tick(); end
        wait_idle(200);
`else
        bseq = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        chk("idle_before_random", 16'(col), 16'(bseq[0]));
`endif

        // Randomized requests and row drive against the reference schedule
        for (int j = 0; j < 400; j++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_key   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) row = 4'($urandom_range(0, 15));
            else                           row = krow[$urandom_range(0, 15)];
            tick();
        end
        in_valid = 1'b0;
        wait_idle(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
